// File: rtl/inv_shift_sub_bytes_pkg.sv
// Shared AES definitions: state geometry, row slices, round-step FSM
// states and the InvShiftRows byte permutation.
package inv_shift_sub_bytes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTE_W  = 8;
    localparam int AES_NB      = 16;
    localparam int AES_ROW_W   = 32;

    // Row r occupies [ROWr_LSB +: 32]; MSB byte of a row is column 0.
    localparam int AES_ROW0_LSB = 96;
    localparam int AES_ROW1_LSB = 64;
    localparam int AES_ROW2_LSB = 32;
    localparam int AES_ROW3_LSB = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SUB  = 1'b1
    } isb_state_e;

    // Row r rotated right by r bytes.
    function automatic logic [127:0] inv_shift_rows(
        input logic [127:0] s
    );
        logic [127:0] r;
        r[AES_ROW0_LSB +: 32] = s[AES_ROW0_LSB +: 32];
        r[AES_ROW1_LSB +: 32] = {s[AES_ROW1_LSB +: 8],
                                 s[AES_ROW1_LSB + 8 +: 24]};
        r[AES_ROW2_LSB +: 32] = {s[AES_ROW2_LSB +: 16],
                                 s[AES_ROW2_LSB + 16 +: 16]};
        r[AES_ROW3_LSB +: 32] = {s[AES_ROW3_LSB +: 24],
                                 s[AES_ROW3_LSB + 24 +: 8]};
        return r;
    endfunction

endpackage

// File: rtl/inv_shift_sub_bytes_inv_sbox.sv
// FIPS-197 inverse S-box, purely combinational.
// Ports: byte_i (8-bit input byte), byte_o (8-bit substituted byte).
module aes_inv_sbox
    import inv_shift_sub_bytes_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    // Entry 0 is the most significant byte of the literal.
    localparam logic [0:255][AES_BYTE_W-1:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign byte_o = INV_SBOX[byte_i];

endmodule

// File: rtl/inv_shift_sub_bytes.sv
// InvShiftRows followed by byte-serial InvSubBytes on one AES state.
// Ports: Clk, Rst_n (async low), En_ISB start, In_ISB state in,
//        Busy_ISB in flight, Ry_ISB done pulse, Out_ISB result.
module inv_shift_sub_bytes
    import inv_shift_sub_bytes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 1
)
(
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         En_ISB,
    input  logic [127:0] In_ISB,
    output logic         Busy_ISB,
    output logic         Ry_ISB,
    output logic [127:0] Out_ISB
);

    localparam int N     = AES_NB / BYTES_PER_CYCLE;
    localparam int GRP_W = BYTES_PER_CYCLE * AES_BYTE_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 ||
          BYTES_PER_CYCLE == 4 || BYTES_PER_CYCLE == 8 ||
          BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
        $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    isb_state_e         state_q, state_d;
    logic [127:0]       work_q, work_d;
    logic [127:0]       out_q, out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ry_q, ry_d;

    logic [6:0]         grp_lsb;
    logic [GRP_W-1:0]   grp_in;
    logic [GRP_W-1:0]   grp_out;
    logic               last;

    // Group 0 is the most significant GRP_W bits of the state.
    always_comb begin
        grp_lsb = 7'((N - 1 - int'(cnt_q)) * GRP_W);
        grp_in  = work_q[grp_lsb +: GRP_W];
        last    = (cnt_q == CNT_W'(N - 1));
    end

    for (genvar i = 0; i < BYTES_PER_CYCLE; i++) begin : g_sbox
        aes_inv_sbox u_sbox (
            .byte_i (grp_in[i*AES_BYTE_W +: AES_BYTE_W]),
            .byte_o (grp_out[i*AES_BYTE_W +: AES_BYTE_W])
        );
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        ry_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (En_ISB) begin
                    work_d  = inv_shift_rows(In_ISB);
                    cnt_d   = '0;
                    state_d = ST_SUB;
                end
            end
            ST_SUB: begin
                work_d[grp_lsb +: GRP_W] = grp_out;
                if (last) begin
                    // Result includes the group substituted this edge.
                    out_d   = work_d;
                    ry_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            ry_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            ry_q    <= ry_d;
        end
    end

    assign Busy_ISB = (state_q == ST_SUB);
    assign Ry_ISB   = ry_q;
    assign Out_ISB  = out_q;

endmodule

// File: tb/tb_inv_shift_sub_bytes.sv
// Scoreboard bench for inv_shift_sub_bytes at 1, 4 and 16 bytes/cycle,
// with a GF(2^8)-derived reference model.
module tb_inv_shift_sub_bytes;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         en_aux = 1'b0;
    logic [127:0] din = '0;
    logic [2:0]   busy_w;
    logic [2:0]   ry_w;
    logic [127:0] dout_w [3];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {
        logic [127:0] d;
        int           cyc;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t sb2[$];

    logic [7:0] sbox_m  [256];
    logic [7:0] isbox_m [256];

    inv_shift_sub_bytes #(.BYTES_PER_CYCLE(1)) u_dut1 (
        .Clk(clk), .Rst_n(rst_n), .En_ISB(en), .In_ISB(din),
        .Busy_ISB(busy_w[0]), .Ry_ISB(ry_w[0]), .Out_ISB(dout_w[0])
    );
    inv_shift_sub_bytes #(.BYTES_PER_CYCLE(4)) u_dut4 (
        .Clk(clk), .Rst_n(rst_n), .En_ISB(en_aux), .In_ISB(din),
        .Busy_ISB(busy_w[1]), .Ry_ISB(ry_w[1]), .Out_ISB(dout_w[1])
    );
    inv_shift_sub_bytes #(.BYTES_PER_CYCLE(16)) u_dut16 (
        .Clk(clk), .Rst_n(rst_n), .En_ISB(en_aux), .In_ISB(din),
        .Busy_ISB(busy_w[2]), .Ry_ISB(ry_w[2]), .Out_ISB(dout_w[2])
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        for (int y = 1; y < 256; y++)
            if (gmul(a, 8'(y)) == 8'h01) return 8'(y);
        return 8'h00;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [7:0] getb(input logic [127:0] s,
                                        input int r, input int c);
        return s[127 - 8*(4*r + c) -: 8];
    endfunction

    function automatic logic [127:0] model_isb(input logic [127:0] s);
        logic [127:0] o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127 - 8*(4*r + c) -: 8] =
                    isbox_m[getb(s, r, (c - r + 4) % 4)];
        return o;
    endfunction

    function automatic logic [127:0] fwd_sub_shift(input logic [127:0] s);
        logic [127:0] o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127 - 8*(4*r + c) -: 8] =
                    sbox_m[getb(s, r, (c + r) % 4)];
        return o;
    endfunction

    // ---------------- checking ----------------
    task automatic chk128(input string nm, input logic [127:0] got,
                          input logic [127:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic mon_one(input int id, input logic [127:0] got,
                           input exp_t e);
        chk128($sformatf("data_dut%0d", id), got, e.d);
        chk_int($sformatf("latency_dut%0d", id), cyc, e.cyc);
    endtask

    task automatic spurious(input int id);
        n_chk++;
        n_fail++;
        $display("FAIL spurious_ry dut%0d got 1 want 0", id);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (ry_w[0]) begin
                if (sb0.size() == 0) spurious(0);
                else mon_one(0, dout_w[0], sb0.pop_front());
            end
            if (ry_w[1]) begin
                if (sb1.size() == 0) spurious(1);
                else mon_one(1, dout_w[1], sb1.pop_front());
            end
            if (ry_w[2]) begin
                if (sb2.size() == 0) spurious(2);
                else mon_one(2, dout_w[2], sb2.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic issue(input logic [127:0] d, input logic [127:0] e,
                         input bit aux);
        @(negedge clk);
        din = d;
        en = 1'b1;
        en_aux = aux;
        sb0.push_back('{e, cyc + 1 + 16});
        if (aux) begin
            sb1.push_back('{e, cyc + 1 + 4});
            sb2.push_back('{e, cyc + 1 + 1});
        end
        @(negedge clk);
        en = 1'b0;
        en_aux = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while ((sb0.size() != 0 || sb1.size() != 0 || sb2.size() != 0)
               && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout pending %0d/%0d/%0d want 0",
                     sb0.size(), sb1.size(), sb2.size());
            sb0.delete();
            sb1.delete();
            sb2.delete();
        end
    endtask

    initial begin
        logic [127:0] a, b, x, o, perm_exp;
        int bc, rc, k, c0;

        for (int v = 0; v < 256; v++) begin
            sbox_m[v] = ginv(8'(v));
            sbox_m[v] = sbox_m[v] ^ rotl(sbox_m[v], 1) ^
                        rotl(sbox_m[v], 2) ^ rotl(sbox_m[v], 3) ^
                        rotl(sbox_m[v], 4) ^ 8'h63;
            isbox_m[v] = ginv(rotl(8'(v), 1) ^ rotl(8'(v), 3) ^
                              rotl(8'(v), 6) ^ 8'h05);
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk_int("reset_busy", int'(busy_w[0]), 0);
        chk_int("reset_ry", int'(ry_w[0]), 0);
        chk128("reset_out", dout_w[0], '0);
        rst_n = 1'b1;
        @(negedge clk);

        // All 0x63 -> all 0x00; busy for exactly 16 cycles
        issue({16{8'h63}}, '0, 1'b0);
        bc = 0;
        for (int i = 0; i < 16; i++) begin
            if (busy_w[0]) bc++;
            @(negedge clk);
        end
        chk_int("busy_cycles", bc, 16);
        chk_int("busy_low_at_ry", int'(busy_w[0]), 0);
        chk_int("ry_at_latency", int'(ry_w[0]), 1);
        wait_done();

        // Permutation check
        perm_exp = 128'h00000000_00010000_00000000_00000001;
        issue(128'h63636363_7c636363_63636363_7c636363, perm_exp, 1'b0);
        wait_done();
        repeat (5) @(negedge clk);
        chk128("out_hold", dout_w[0], perm_exp);

        issue('0, {16{8'h52}}, 1'b1);
        wait_done();
        issue({16{8'h52}}, {16{8'h48}}, 1'b1);
        wait_done();

        // En re-asserted mid-operation is ignored
        a = rnd128();
        b = rnd128();
        issue(a, model_isb(a), 1'b0);
        repeat (2) @(negedge clk);
        din = b;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        wait_done();

        // En during the Ry cycle starts the next state at once
        a = rnd128();
        b = rnd128();
        issue(a, model_isb(a), 1'b0);
        k = 0;
        while (!ry_w[0] && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk_int("ry_seen", int'(ry_w[0]), 1);
        din = b;
        en = 1'b1;
        sb0.push_back('{model_isb(b), cyc + 17});
        @(negedge clk);
        en = 1'b0;
        wait_done();

        // En held high: one state every 17 cycles
        x = rnd128();
        @(negedge clk);
        c0 = cyc;
        din = x;
        en = 1'b1;
        for (int i = 1; i <= 3; i++)
            sb0.push_back('{model_isb(x), c0 + 17 * i});
        repeat (40) @(negedge clk);
        en = 1'b0;
        wait_done();

        // Asynchronous reset with counter at 7
        a = rnd128();
        issue(a, model_isb(a), 1'b0);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_int("midrst_busy", int'(busy_w[0]), 0);
        chk_int("midrst_ry", int'(ry_w[0]), 0);
        chk128("midrst_out", dout_w[0], '0);
        sb0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        rc = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ry_w[0]) rc++;
        end
        chk_int("no_ry_after_rst", rc, 0);
        a = rnd128();
        issue(a, model_isb(a), 1'b1);
        wait_done();

        // Round trip through forward SubBytes+ShiftRows
        for (int i = 0; i < 1000; i++) begin
            o = rnd128();
            issue(fwd_sub_shift(o), o, 1'b1);
            wait_done();
        end

        repeat (5) @(negedge clk);
        chk_int("sb_drained", sb0.size() + sb1.size() + sb2.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
